// File: rtl/ddr4_wr_arbiter.sv
// ddr4_wr_arbiter
//   Shares one 512-bit AXI4 write port to DDR4 between NUM_M burst writers.
//   Round-robin grant per burst, one outstanding transaction at a time:
//   IDLE -> ADDR -> DATA -> RESP -> IDLE. The B response is routed back to the
//   burst owner. The W beat count is checked against the latched AWLEN, and any
//   mismatch sets the sticky err_proto flag.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   s_aw*/s_awvalid/s_awready  per-requester AW channel (packed [NUM_M])
//   s_w*/s_wvalid/s_wready     per-requester W channel
//   s_bresp (shared), s_bvalid/s_bready  per-requester B channel
//   m_aw*, m_w*, m_b*          single DDR-side AXI4 write port
//   grant_id                   current owner (meaningful while busy)
//   busy                       1 whenever the FSM is not IDLE
//   err_proto                  sticky wlast/beat-count mismatch flag
module ddr4_wr_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  localparam int STRB_W = DATA_W / 8,
  localparam int GW     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_M-1:0][ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_M-1:0][7:0]          s_awlen,
  input  logic [NUM_M-1:0][2:0]          s_awsize,
  input  logic [NUM_M-1:0][1:0]          s_awburst,
  input  logic [NUM_M-1:0]               s_awvalid,
  output logic [NUM_M-1:0]               s_awready,
  input  logic [NUM_M-1:0][DATA_W-1:0]   s_wdata,
  input  logic [NUM_M-1:0][STRB_W-1:0]   s_wstrb,
  input  logic [NUM_M-1:0]               s_wlast,
  input  logic [NUM_M-1:0]               s_wvalid,
  output logic [NUM_M-1:0]               s_wready,
  output logic [1:0]                     s_bresp,
  output logic [NUM_M-1:0]               s_bvalid,
  input  logic [NUM_M-1:0]               s_bready,
  output logic [ADDR_W-1:0]              m_awaddr,
  output logic [7:0]                     m_awlen,
  output logic [2:0]                     m_awsize,
  output logic [1:0]                     m_awburst,
  output logic                           m_awvalid,
  input  logic                           m_awready,
  output logic [DATA_W-1:0]              m_wdata,
  output logic [STRB_W-1:0]              m_wstrb,
  output logic                           m_wlast,
  output logic                           m_wvalid,
  input  logic                           m_wready,
  input  logic [1:0]                     m_bresp,
  input  logic                           m_bvalid,
  output logic                           m_bready,
  output logic [GW-1:0]                  grant_id,
  output logic                           busy,
  output logic                           err_proto
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [GW:0]   NUM_M_W = (GW+1)'(NUM_M);
  localparam logic [GW-1:0] LAST_ID = GW'(NUM_M - 1);

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [7:0]    len_q;
  logic [8:0]    beat_cnt;   // 9 bits: counts up to 256 beats

  // Round-robin pick. Rotating the request vector by rr_ptr turns the search
  // into "lowest set bit"; the offset is then added back modulo NUM_M.
  logic [2*NUM_M-1:0] req2;
  logic [GW-1:0]      pick_off;
  logic [GW:0]        pick_sum;
  logic [GW-1:0]      pick_idx;
  logic               pick_vld;

  assign req2     = {s_awvalid, s_awvalid} >> rr_ptr;
  assign pick_vld = |s_awvalid;

  always_comb begin
    pick_off = '0;
    for (int i = NUM_M - 1; i >= 0; i--)
      if (req2[i]) pick_off = GW'(i);
  end

  assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= NUM_M_W) ? GW'(pick_sum - NUM_M_W) : GW'(pick_sum);

  // DDR side: only the granted requester is visible, and only in its phase.
  wire in_addr = (state == ADDR);
  wire in_data = (state == DATA);
  wire in_resp = (state == RESP);

  assign m_awaddr  = s_awaddr[grant_id];
  assign m_awlen   = s_awlen[grant_id];
  assign m_awsize  = s_awsize[grant_id];
  assign m_awburst = s_awburst[grant_id];
  assign m_awvalid = in_addr & s_awvalid[grant_id];
  assign m_wdata   = s_wdata[grant_id];
  assign m_wstrb   = s_wstrb[grant_id];
  assign m_wlast   = s_wlast[grant_id];
  assign m_wvalid  = in_data & s_wvalid[grant_id];
  assign m_bready  = in_resp & s_bready[grant_id];
  assign s_bresp   = m_bresp;

  // Requester side: ready/valid back to the owner only.
  for (genvar g = 0; g < NUM_M; g++) begin : g_lane
    wire own = (grant_id == GW'(g));
    assign s_awready[g] = own & in_addr & m_awready;
    assign s_wready[g]  = own & in_data & m_wready;
    assign s_bvalid[g]  = own & in_resp & m_bvalid;
  end

  wire aw_hs     = m_awvalid & m_awready;
  wire w_hs      = m_wvalid & m_wready;
  wire b_hs      = m_bvalid & m_bready;
  wire last_beat = (beat_cnt == {1'b0, len_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      err_proto <= 1'b0;
      beat_cnt  <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant_id <= pick_idx;
          busy     <= 1'b1;
          state    <= ADDR;
        end
        ADDR: if (aw_hs) begin
          len_q    <= m_awlen;
          beat_cnt <= '0;
          state    <= DATA;
        end
        DATA: if (w_hs) begin
          beat_cnt <= beat_cnt + 9'd1;
          // Beat is forwarded regardless; a misplaced or missing wlast only flags.
          if (m_wlast != last_beat) err_proto <= 1'b1;
          if (m_wlast || last_beat) state <= RESP;
        end
        RESP: if (b_hs) begin
          rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_wr_arbiter.sv
// tb_ddr4_wr_arbiter
//   Requester tasks drive bursts; a DDR-side model applies backpressure and
//   checks every AW/W/B against a queue of expected bursts pushed by the test.
module tb_ddr4_wr_arbiter;
  localparam int NUM_M = 2, ADDR_W = 32, DATA_W = 512, STRB_W = DATA_W / 8;
  localparam int LIM = 1000;

  logic clk, rst_n;
  logic [NUM_M-1:0][ADDR_W-1:0] s_awaddr;
  logic [NUM_M-1:0][7:0]        s_awlen;
  logic [NUM_M-1:0][2:0]        s_awsize;
  logic [NUM_M-1:0][1:0]        s_awburst;
  logic [NUM_M-1:0]             s_awvalid, s_awready;
  logic [NUM_M-1:0][DATA_W-1:0] s_wdata;
  logic [NUM_M-1:0][STRB_W-1:0] s_wstrb;
  logic [NUM_M-1:0]             s_wlast, s_wvalid, s_wready;
  logic [1:0]                   s_bresp;
  logic [NUM_M-1:0]             s_bvalid, s_bready;
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0]        m_awlen;
  logic [2:0]        m_awsize;
  logic [1:0]        m_awburst;
  logic              m_awvalid, m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wlast, m_wvalid, m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid, m_bready;
  logic [0:0]        grant_id;
  logic              busy, err_proto;

  ddr4_wr_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .grant_id(grant_id), .busy(busy), .err_proto(err_proto)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  // wlast_at: beat index carrying wlast (-1 = never). nbeats: beats the DUT
  // should accept before moving to RESP. exp_err: err_proto after the burst.
  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [7:0]  len;
    int          wlast_at;
    int          nbeats;
    logic [1:0]  bresp;
    bit          rst_before;
    bit          exp_err;
  } vec_t;

  int   nvec = 0, nerr = 0;
  vec_t exp_aw[$];
  vec_t cur;
  bit   aw_active, b_pending, w_toggle, abort;
  int   w_idx, b_cnt, b_delay, aw_stall_left;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int m, input logic [31:0] a, input int i);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++)
      d[k*32 +: 32] = (a + 32'(i * 64) + 32'(k)) ^ 32'(m << 24);
    return d;
  endfunction

  // DDR-side model: samples at negedge, updates its outputs 1 time unit after posedge.
  initial begin
    logic [NUM_M-1:0] leak;
    int owner;
    bit b_hs;
    m_awready = 1; m_wready = 1; m_bvalid = 0; m_bresp = 0;
    aw_active = 0; b_pending = 0; w_idx = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      b_hs = 0;
      if (!rst_n) begin
        aw_active = 0; b_pending = 0; w_idx = 0;
      end else begin
        owner = aw_active ? cur.m : (exp_aw.size() > 0 ? exp_aw[0].m : -1);
        leak = '0;
        for (int i = 0; i < NUM_M; i++)
          if (i != owner) leak[i] = s_awready[i] | s_wready[i] | s_bvalid[i];
        chk("non_owner_quiet", 64'(leak), 64'(0));
        if (m_awvalid && m_awready) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
          else begin
            cur = exp_aw.pop_front();
            chk("aw_grant", 64'(grant_id), 64'(cur.m));
            chk("aw_addr", 64'(m_awaddr), 64'(cur.addr));
            chk("aw_len", 64'(m_awlen), 64'(cur.len));
            chk("aw_size_burst", 64'({m_awsize, m_awburst}), 64'({3'd6, 2'd1}));
            aw_active = 1; w_idx = 0;
          end
        end
        if (m_wvalid && m_wready) begin
          if (!aw_active || w_idx >= cur.nbeats) chk("w_unexpected", 64'(1), 64'(0));
          else begin
            nvec++;
            if (m_wdata !== pat(cur.m, cur.addr, w_idx)) begin
              nerr++;
              $display("FAIL w_data beat %0d: got %h expected %h", w_idx,
                       m_wdata[63:0], pat(cur.m, cur.addr, w_idx) & 512'hFFFF_FFFF_FFFF_FFFF);
            end
            chk("w_last", 64'(m_wlast), 64'(w_idx == cur.wlast_at));
            chk("w_strb", 64'(&m_wstrb), 64'(1));
            if (w_idx == cur.nbeats - 1) begin b_pending = 1; b_cnt = b_delay; end
            w_idx++;
          end
        end
        if (m_bvalid && m_bready) begin
          chk("b_beat_count", 64'(w_idx), 64'(cur.nbeats));
          aw_active = 0; b_pending = 0; b_hs = 1;
        end
      end
      @(posedge clk); #1;
      if (!rst_n) m_bvalid = 0;
      else begin
        if (aw_stall_left > 0 && m_awvalid) aw_stall_left--;
        m_awready = (aw_stall_left == 0);
        m_wready  = w_toggle ? ~m_wready : 1'b1;
        if (b_hs) m_bvalid = 0;
        if (b_pending && !m_bvalid) begin
          if (b_cnt == 0) begin m_bvalid = 1; m_bresp = cur.bresp; end
          else b_cnt--;
        end
      end
    end
  end

  // Requester-side burst: AW, then nbeats W beats, then B. Exits early on abort.
  task automatic burst(input vec_t v);
    int n;
    s_awaddr[v.m] = v.addr; s_awlen[v.m] = v.len;
    s_awsize[v.m] = 3'd6; s_awburst[v.m] = 2'd1; s_awvalid[v.m] = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready[v.m] && n < LIM && !abort);
    if (abort) begin s_awvalid[v.m] = 0; return; end
    if (!s_awready[v.m]) chk("aw_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    s_awvalid[v.m] = 0;
    for (int i = 0; i < v.nbeats; i++) begin
      s_wdata[v.m] = pat(v.m, v.addr, i); s_wstrb[v.m] = '1;
      s_wlast[v.m] = (i == v.wlast_at); s_wvalid[v.m] = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_wready[v.m] && n < LIM && !abort);
      if (abort) begin s_wvalid[v.m] = 0; s_wlast[v.m] = 0; return; end
      if (!s_wready[v.m]) chk("w_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
    end
    s_wvalid[v.m] = 0; s_wlast[v.m] = 0; s_bready[v.m] = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_bvalid[v.m] && n < LIM && !abort);
    if (abort) begin s_bready[v.m] = 0; return; end
    chk("b_valid", 64'(s_bvalid[v.m]), 64'(1));
    chk("b_resp", 64'(s_bresp), 64'(v.bresp));
    @(posedge clk); #1;
    s_bready[v.m] = 0;
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    exp_aw.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'(0));
    chk({nm, "_grant"}, 64'(grant_id), 64'(0));
    chk({nm, "_m_valid_ready"}, 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
    chk({nm, "_s_ready_valid"}, 64'({s_awready, s_wready, s_bvalid}), 64'(0));
  endtask

  vec_t tbl[8];
  vec_t v, v2;
  time  t0;

  initial begin
    tbl[0] = '{1, 32'h2000, 8'd0,   0,   1,   2'b00, 0, 0};
    tbl[1] = '{0, 32'h3000, 8'd3,   3,   4,   2'b10, 0, 0};  // SLVERR passes through
    tbl[2] = '{1, 32'h4000, 8'd7,   7,   8,   2'b01, 0, 0};
    tbl[3] = '{0, 32'h4800, 8'd255, 255, 256, 2'b00, 0, 0};  // longest burst
    tbl[4] = '{0, 32'h5000, 8'd3,   1,   2,   2'b00, 0, 1};  // early wlast
    tbl[5] = '{1, 32'h6000, 8'd1,   1,   2,   2'b00, 0, 1};  // normal, err sticky
    tbl[6] = '{0, 32'h7000, 8'd2,   -1,  3,   2'b00, 1, 1};  // wlast missing
    tbl[7] = '{1, 32'h9000, 8'd2,   0,   1,   2'b11, 1, 1};  // wlast on first beat

    rst_n = 0; abort = 0; w_toggle = 0; b_delay = 0; aw_stall_left = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_err", 64'(err_proto), 64'(0));
    @(posedge clk); #1 rst_n = 1;

    // single burst: m_awvalid one cycle after s_awvalid, busy drops after B
    v = '{0, 32'h1000, 8'd1, 1, 2, 2'b00, 0, 0};
    exp_aw.push_back(v);
    fork
      burst(v);
      begin
        @(negedge clk);
        chk("t1_awvalid_c0", 64'({m_awvalid, busy}), 64'(0));
        @(negedge clk);
        chk("t1_awvalid_c1", 64'({m_awvalid, busy, grant_id}), 64'(3'b110));
      end
    join
    @(negedge clk);
    chk("t1_busy_after_b", 64'(busy), 64'(0));
    chk("t1_err", 64'(err_proto), 64'(0));
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      exp_aw.push_back(tbl[i]);
      burst(tbl[i]);
      @(negedge clk);
      chk("vec_err_proto", 64'(err_proto), 64'(tbl[i].exp_err));
      chk("vec_busy", 64'(busy), 64'(0));
      chk("vec_queue_empty", 64'(exp_aw.size()), 64'(0));
      @(posedge clk); #1;
    end

    // round-robin from rr_ptr=0: grants 0,1,0,1, four cycles per burst
    do_reset();
    v  = '{0, 32'h100, 8'd0, 0, 1, 2'b00, 0, 0};
    v2 = '{1, 32'h200, 8'd0, 0, 1, 2'b00, 0, 0};
    exp_aw.push_back(v); exp_aw.push_back(v2);
    v.addr = 32'h140; v2.addr = 32'h240;
    exp_aw.push_back(v); exp_aw.push_back(v2);
    t0 = $time;
    fork
      begin v.addr = 32'h100; burst(v); v.addr = 32'h140; burst(v); end
      begin v2.addr = 32'h200; burst(v2); v2.addr = 32'h240; burst(v2); end
    join
    chk("rr_elapsed", 64'($time - t0), 64'(160));
    chk("rr_queue_empty", 64'(exp_aw.size()), 64'(0));

    // backpressure with M1 waiting
    aw_stall_left = 5; m_awready = 0; w_toggle = 1; b_delay = 10;
    v  = '{0, 32'hC000, 8'd3, 3, 4, 2'b00, 0, 0};
    v2 = '{1, 32'hD000, 8'd1, 1, 2, 2'b00, 0, 0};
    exp_aw.push_back(v); exp_aw.push_back(v2);
    fork
      burst(v);
      begin @(posedge clk); #1; burst(v2); end
    join
    w_toggle = 0; b_delay = 0;
    chk("bp_queue_empty", 64'(exp_aw.size()), 64'(0));
    chk("bp_err", 64'(err_proto), 64'(0));

    // reset in the middle of a 4-beat burst after its second beat
    v = '{0, 32'hA000, 8'd3, 3, 4, 2'b00, 0, 0};
    exp_aw.push_back(v);
    fork
      burst(v);
      begin
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (w_idx < 2 && n < LIM);
        chk("rst_mid_reached", 64'(w_idx >= 2), 64'(1));
        #1 rst_n = 0; abort = 1;
        #1 chk_idle_outputs("rst_mid");
        chk("rst_mid_err", 64'(err_proto), 64'(0));
      end
    join
    clear_inputs();
    exp_aw.delete();
    @(posedge clk); #1 rst_n = 1; abort = 0;
    v2 = '{1, 32'hB000, 8'd1, 1, 2, 2'b00, 0, 0};
    exp_aw.push_back(v2);
    burst(v2);
    chk("rst_fresh_queue_empty", 64'(exp_aw.size()), 64'(0));

    // long burst from M0 with M1 pending: all 18 beats go first
    v  = '{0, 32'hE000, 8'd17, 17, 18, 2'b00, 0, 0};
    v2 = '{1, 32'hF000, 8'd0, 0, 1, 2'b00, 0, 0};
    exp_aw.push_back(v); exp_aw.push_back(v2);
    fork
      burst(v);
      begin @(posedge clk); #1; burst(v2); end
    join
    @(negedge clk);
    chk("long_err", 64'(err_proto), 64'(0));
    chk("long_queue_empty", 64'(exp_aw.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
